// File: rtl/fpu_tag_table_pkg.sv
// Shared FPU types for the tag table.
// Holds lane counts, bundle typedefs and the tag-width helper.
package fpu_tag_table_pkg;

  localparam int NUM_THREADS = 2;
  localparam int META_W      = 32;

  typedef logic [4:0]        fflags_t;
  typedef logic [META_W-1:0] meta_t;

  localparam int DATA_W = NUM_THREADS * 32;
  localparam int FLAG_W = NUM_THREADS * $bits(fflags_t);

  function automatic int log2up(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fpu_tag_table_alloc.sv
// Lowest-index priority encoder.
// Finds the first free tag in the bitmap.
module fpu_tag_alloc
  import fpu_tag_table_pkg::*;
#(
  parameter int N = 8,
  parameter int W = log2up(N)
) (
  input  logic [N-1:0] i_bits,
  output logic [W-1:0] o_idx,
  output logic         o_valid
);

  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_bits[i]) begin
        o_idx   = W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_tag_table.sv
// Tag allocator and metadata store in front of the FPU wrapper.
// Out-of-order results regain their metadata in one output stage.
module fpu_tag_table
  import fpu_tag_table_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int METAW = META_W,
  parameter int DATAW = DATA_W,
  parameter int FLAGW = FLAG_W,
  parameter int TAGW  = log2up(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [METAW-1:0] req_meta,
  output logic             fpu_valid,
  input  logic             fpu_ready,
  output logic [TAGW-1:0]  fpu_tag,
  input  logic             rsp_valid,
  output logic             rsp_ready,
  input  logic [TAGW-1:0]  rsp_tag,
  input  logic [DATAW-1:0] rsp_data,
  input  logic             rsp_has_fflags,
  input  logic [FLAGW-1:0] rsp_fflags,
  output logic             cmt_valid,
  input  logic             cmt_ready,
  output logic [METAW-1:0] cmt_meta,
  output logic [DATAW-1:0] cmt_data,
  output logic             cmt_has_fflags,
  output logic [FLAGW-1:0] cmt_fflags,
  output logic             empty
);

  logic [DEPTH-1:0] r_free;
  logic [TAGW:0]    r_count;
  logic [METAW-1:0] r_meta [DEPTH];
  logic             r_cmt_valid;

  logic [TAGW-1:0] w_tag;
  logic            w_any_free;
  logic            w_full;
  logic            w_issue;
  logic            w_rel;

  fpu_tag_alloc #(
    .N (DEPTH),
    .W (TAGW)
  ) u_alloc (
    .i_bits  (r_free),
    .o_idx   (w_tag),
    .o_valid (w_any_free)
  );

  assign w_full    = (r_count == (TAGW+1)'(DEPTH));
  assign fpu_valid = req_valid & ~w_full;
  assign req_ready = fpu_ready & ~w_full;
  assign fpu_tag   = w_tag;
  assign w_issue   = req_valid & fpu_ready & ~w_full;

  assign rsp_ready = ~r_cmt_valid | cmt_ready;
  assign w_rel     = rsp_valid & rsp_ready;

  assign cmt_valid = r_cmt_valid;
  assign empty     = (r_count == '0) & ~r_cmt_valid;

  // issue and release never target the same tag in one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_free <= '1;
    end else begin
      if (w_issue) r_free[w_tag]   <= 1'b0;
      if (w_rel)   r_free[rsp_tag] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_issue && !w_rel) begin
      r_count <= r_count + 1'b1;
    end else if (w_rel && !w_issue) begin
      r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue) r_meta[w_tag] <= req_meta;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmt_valid <= 1'b0;
    end else if (w_rel) begin
      r_cmt_valid <= 1'b1;
    end else if (cmt_ready) begin
      r_cmt_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rel) begin
      cmt_meta       <= r_meta[rsp_tag];
      cmt_data       <= rsp_data;
      cmt_has_fflags <= rsp_has_fflags;
      cmt_fflags     <= rsp_fflags;
    end
  end

  a_legal_release: assert property (
    @(posedge clk) disable iff (reset)
    w_rel |-> !r_free[rsp_tag]
  );

  a_alloc_ok: assert property (
    @(posedge clk) disable iff (reset)
    !w_full |-> w_any_free
  );

endmodule

// File: tb/tb_fpu_tag_table.sv
// Self-checking bench for fpu_tag_table.
// Directed scenarios plus random traffic against a tag-set model.
module tb_fpu_tag_table;

  localparam int DEPTH = 8;
  localparam int TAGW  = 3;
  localparam int METAW = 32;
  localparam int DATAW = 64;
  localparam int FLAGW = 10;

  logic             clk;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [METAW-1:0] req_meta;
  logic             fpu_valid;
  logic             fpu_ready;
  logic [TAGW-1:0]  fpu_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [TAGW-1:0]  rsp_tag;
  logic [DATAW-1:0] rsp_data;
  logic             rsp_has_fflags;
  logic [FLAGW-1:0] rsp_fflags;
  logic             cmt_valid;
  logic             cmt_ready;
  logic [METAW-1:0] cmt_meta;
  logic [DATAW-1:0] cmt_data;
  logic             cmt_has_fflags;
  logic [FLAGW-1:0] cmt_fflags;
  logic             empty;

  fpu_tag_table dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_meta       (req_meta),
    .fpu_valid      (fpu_valid),
    .fpu_ready      (fpu_ready),
    .fpu_tag        (fpu_tag),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_tag        (rsp_tag),
    .rsp_data       (rsp_data),
    .rsp_has_fflags (rsp_has_fflags),
    .rsp_fflags     (rsp_fflags),
    .cmt_valid      (cmt_valid),
    .cmt_ready      (cmt_ready),
    .cmt_meta       (cmt_meta),
    .cmt_data       (cmt_data),
    .cmt_has_fflags (cmt_has_fflags),
    .cmt_fflags     (cmt_fflags),
    .empty          (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec;
  int miss;

  bit             m_busy [DEPTH];
  logic [31:0]    m_meta [DEPTH];
  bit             m_cv;
  logic [31:0]    m_cmeta;
  logic [63:0]    m_cdata;
  bit             m_chf;
  logic [9:0]     m_cff;

  function automatic int nbusy();
    int n;
    n = 0;
    for (int i = 0; i < DEPTH; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  function automatic int lowfree();
    for (int i = 0; i < DEPTH; i++) if (!m_busy[i]) return i;
    return 0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
    m_cv = 1'b0;
  endtask

  task automatic idle();
    req_valid      = 1'b0;
    req_meta       = '0;
    fpu_ready      = 1'b1;
    rsp_valid      = 1'b0;
    rsp_tag        = '0;
    rsp_data       = '0;
    rsp_has_fflags = 1'b0;
    rsp_fflags     = '0;
    cmt_ready      = 1'b1;
  endtask

  // one clock: apply the handshake rules to the model at the edge
  task automatic tick();
    bit iss;
    bit rel;
    int t;
    iss = req_valid && fpu_ready && (nbusy() < DEPTH);
    rel = rsp_valid && (!m_cv || cmt_ready);
    t   = lowfree();
    @(posedge clk);
    if (rel) begin
      m_cv    = 1'b1;
      m_cmeta = m_meta[rsp_tag];
      m_cdata = rsp_data;
      m_chf   = rsp_has_fflags;
      m_cff   = rsp_fflags;
      m_busy[rsp_tag] = 1'b0;
    end else if (m_cv && cmt_ready) begin
      m_cv = 1'b0;
    end
    if (iss) begin
      m_busy[t] = 1'b1;
      m_meta[t] = req_meta;
    end
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    vec++;
    if ({fpu_tag, rsp_ready, cmt_valid, empty} !== {3'd0, 3'b101}) begin
      miss++;
      $display("FAIL reset_state got tag=%0d rr=%b cv=%b e=%b want 0 1 0 1",
               fpu_tag, rsp_ready, cmt_valid, empty);
    end
    req_valid = 1'b1;
    #1;
    vec++;
    if ({fpu_valid, req_ready} !== 2'b11) begin
      miss++;
      $display("FAIL reset_pass got fv=%b rq=%b want 1 1",
               fpu_valid, req_ready);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      req_valid = 1'b1;
      req_meta  = 32'h10 + 32'(i);
      #1;
      vec++;
      if ({fpu_valid, req_ready, fpu_tag} !== {2'b11, 3'(i)}) begin
        miss++;
        $display("FAIL fill_tag%0d got fv=%b rq=%b tag=%0d want 1 1 %0d",
                 i, fpu_valid, req_ready, fpu_tag, i);
      end
      tick();
    end
    req_meta = 32'hDEAD;
    #1;
    vec++;
    if ({fpu_valid, req_ready, empty} !== 3'b000) begin
      miss++;
      $display("FAIL fill_9th got fv=%b rq=%b e=%b want 0 0 0",
               fpu_valid, req_ready, empty);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_out_of_order();
    int          tg [3];
    logic [63:0] d;
    logic [9:0]  f;
    tg = '{5, 2, 7};
    cmt_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d = {32'(tg[k]), 32'hCAFE0000 | 32'(k)};
      f = 10'(tg[k] * 37 + 1);
      rsp_valid      = 1'b1;
      rsp_tag        = 3'(tg[k]);
      rsp_data       = d;
      rsp_fflags     = f;
      rsp_has_fflags = k[0];
      tick();
      vec++;
      if ({cmt_valid, cmt_meta, cmt_data, cmt_has_fflags, cmt_fflags} !==
          {1'b1, 32'h10 + 32'(tg[k]), d, k[0], f}) begin
        miss++;
        $display("FAIL ooo_tag%0d got v=%b m=%h d=%h h=%b f=%h want 1 %h %h %b %h",
                 tg[k], cmt_valid, cmt_meta, cmt_data, cmt_has_fflags,
                 cmt_fflags, 32'h10 + 32'(tg[k]), d, k[0], f);
      end
    end
    rsp_valid = 1'b0;
    tick();
    vec++;
    if (cmt_valid !== 1'b0) begin
      miss++;
      $display("FAIL ooo_drain got cv=%b want 0", cmt_valid);
    end
  endtask

  task automatic test_full_simul();
    int exp_t [3];
    exp_t = '{2, 5, 7};
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_meta  = 32'h20 + 32'(i);
      #1;
      vec++;
      if (fpu_tag !== 3'(exp_t[i])) begin
        miss++;
        $display("FAIL refill%0d got tag=%0d want %0d", i, fpu_tag, exp_t[i]);
      end
      tick();
    end
    req_meta  = 32'h33;
    rsp_valid = 1'b1;
    rsp_tag   = 3'd3;
    #1;
    vec++;
    if ({req_ready, fpu_valid} !== 2'b00) begin
      miss++;
      $display("FAIL full_stall got rq=%b fv=%b want 0 0", req_ready, fpu_valid);
    end
    tick();
    rsp_valid = 1'b0;
    #1;
    vec++;
    if ({req_ready, fpu_tag, cmt_meta} !== {1'b1, 3'd3, 32'h13}) begin
      miss++;
      $display("FAIL full_reuse got rq=%b tag=%0d m=%h want 1 3 13",
               req_ready, fpu_tag, cmt_meta);
    end
    tick();
    #1;
    vec++;
    if (req_ready !== 1'b0) begin
      miss++;
      $display("FAIL full_again got rq=%b want 0", req_ready);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    cmt_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_tag   = 3'd0;
    rsp_data  = 64'hA0;
    tick();
    rsp_tag  = 3'd1;
    rsp_data = 64'hA1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vec++;
      if ({cmt_valid, cmt_meta, cmt_data, rsp_ready} !==
          {1'b1, 32'h10, 64'hA0, 1'b0}) begin
        miss++;
        $display("FAIL bp_hold%0d got v=%b m=%h d=%h rr=%b want 1 10 a0 0",
                 i, cmt_valid, cmt_meta, cmt_data, rsp_ready);
      end
      tick();
    end
    cmt_ready = 1'b1;
    #1;
    vec++;
    if (rsp_ready !== 1'b1) begin
      miss++;
      $display("FAIL bp_release got rr=%b want 1", rsp_ready);
    end
    tick();
    rsp_valid = 1'b0;
    vec++;
    if ({cmt_valid, cmt_meta, cmt_data} !== {1'b1, 32'h11, 64'hA1}) begin
      miss++;
      $display("FAIL bp_second got v=%b m=%h d=%h want 1 11 a1",
               cmt_valid, cmt_meta, cmt_data);
    end
    tick();
    vec++;
    if ({cmt_valid, empty} !== 2'b00) begin
      miss++;
      $display("FAIL bp_drain got v=%b e=%b want 0 0", cmt_valid, empty);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_meta  = 32'h40 + 32'(i);
      tick();
    end
    cmt_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_tag   = 3'd1;
    req_meta  = 32'h44;
    tick();
    req_valid = 1'b0;
    rsp_valid = 1'b0;
    vec++;
    if ({cmt_valid, empty, cmt_meta} !== {2'b10, 32'h41}) begin
      miss++;
      $display("FAIL mid_pre got v=%b e=%b m=%h want 1 0 41",
               cmt_valid, empty, cmt_meta);
    end
    #2 reset = 1'b1;
    model_clear();
    #1;
    vec++;
    if ({cmt_valid, empty, fpu_tag, rsp_ready} !== {2'b01, 3'd0, 1'b1}) begin
      miss++;
      $display("FAIL mid_reset got v=%b e=%b tag=%0d rr=%b want 0 1 0 1",
               cmt_valid, empty, fpu_tag, rsp_ready);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    cmt_ready = 1'b1;
    req_valid = 1'b1;
    req_meta  = 32'h50;
    #1;
    vec++;
    if ({fpu_tag, req_ready} !== {3'd0, 1'b1}) begin
      miss++;
      $display("FAIL mid_next got tag=%0d rq=%b want 0 1", fpu_tag, req_ready);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_random();
    int  q [$];
    bit  full;
    for (int c = 0; c < 600; c++) begin
      req_valid      = ($urandom_range(0, 3) != 0);
      req_meta       = $urandom;
      fpu_ready      = ($urandom_range(0, 3) != 0);
      cmt_ready      = ($urandom_range(0, 2) != 0);
      rsp_data       = {$urandom, $urandom};
      rsp_has_fflags = 1'($urandom);
      rsp_fflags     = 10'($urandom);
      q.delete();
      for (int i = 0; i < DEPTH; i++) if (m_busy[i]) q.push_back(i);
      rsp_valid = (q.size() > 0) && ($urandom_range(0, 1) != 0);
      rsp_tag   = (q.size() > 0) ? 3'(q[$urandom_range(0, q.size() - 1)]) : 3'd0;
      #1;
      full = (nbusy() == DEPTH);
      vec++;
      if ({fpu_valid, req_ready, rsp_ready} !==
          {req_valid && !full, fpu_ready && !full, !m_cv || cmt_ready}) begin
        miss++;
        $display("FAIL rnd_hs c%0d got fv=%b rq=%b rr=%b full=%b cv=%b",
                 c, fpu_valid, req_ready, rsp_ready, full, m_cv);
      end
      if (!full) begin
        vec++;
        if (fpu_tag !== 3'(lowfree())) begin
          miss++;
          $display("FAIL rnd_tag c%0d got %0d want %0d", c, fpu_tag, lowfree());
        end
      end
      tick();
      vec++;
      if ({cmt_valid, empty} !== {m_cv, (nbusy() == 0) && !m_cv}) begin
        miss++;
        $display("FAIL rnd_stat c%0d got v=%b e=%b want %b %b",
                 c, cmt_valid, empty, m_cv, (nbusy() == 0) && !m_cv);
      end
      if (m_cv) begin
        vec++;
        if ({cmt_meta, cmt_data, cmt_has_fflags, cmt_fflags} !==
            {m_cmeta, m_cdata, m_chf, m_cff}) begin
          miss++;
          $display("FAIL rnd_cmt c%0d got m=%h d=%h h=%b f=%h want %h %h %b %h",
                   c, cmt_meta, cmt_data, cmt_has_fflags, cmt_fflags,
                   m_cmeta, m_cdata, m_chf, m_cff);
        end
      end
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec  = 0;
    miss = 0;
    idle();
    reset = 1'b1;
    test_reset();
    test_fill();
    test_out_of_order();
    test_full_simul();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
